ddr2_local_traffic_master: RTL and testbench



---
 rtl/ddr2_local_traffic_master.sv | 182 ++++++++++++++++++
 tb/tb_ddr2_local_traffic_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_local_traffic_master.sv
`default_nettype none
// ============================================================================
// Module : ddr2_local_traffic_master
// Brief  : LFSR write/read-back self-test initiator on the DDR2 local port.
// Rev    : 1.0
// ============================================================================
module ddr2_local_traffic_master #(
  parameter int          ADDR_W          = 25,
  parameter int          DATA_W          = 32,
  parameter int          BE_W            = 4,
  parameter int          BURST_LEN       = 2,
  parameter int          NUM_WORDS       = 1024,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [31:0] SEED            = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              local_init_done,
  input  logic              local_ready,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [2:0]        local_size,
  output logic [BE_W-1:0]   local_be,
  output logic [DATA_W-1:0] local_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int                OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0]       POLY      = 32'h8020_0003;
  localparam logic [ADDR_W-1:0] BL_A      = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(NUM_WORDS - BURST_LEN);
  localparam logic [2:0]        BL_M1     = 3'(BURST_LEN - 1);
  localparam logic [OUT_W-1:0]  BL_O      = OUT_W'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WRITE     = 3'd2,
    S_READ      = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       wlfsr_q, wlfsr_d, clfsr_q, clfsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, chk_q, chk_d, first_q, first_d;
  logic [2:0]        beat_q, beat_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [15:0]       err_q, err_d;
  logic              wr_req, rd_req, wr_acc, rd_acc, rd_beat;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Read issue is gated only by the in-flight window; since the window can
  // only shrink through acceptance, an unaccepted request is never withdrawn.
  assign wr_req  = (state_q == S_WRITE);
  assign rd_req  = (state_q == S_READ) &&
                   ((32'(out_q) + 32'(BURST_LEN)) <= 32'(MAX_OUTSTANDING));
  assign wr_acc  = wr_req && local_ready;
  assign rd_acc  = rd_req && local_ready;
  assign rd_beat = local_rdata_valid && ((state_q == S_READ) || (state_q == S_DRAIN));

  always_comb begin
    state_d = state_q;
    wlfsr_d = wlfsr_q;
    clfsr_d = clfsr_q;
    addr_d  = addr_q;
    chk_d   = chk_q;
    first_d = first_q;
    beat_d  = beat_q;
    err_d   = err_q;
    out_d   = out_q + (rd_acc ? BL_O : '0) - (rd_beat ? OUT_W'(1) : '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT_INIT;
          wlfsr_d = SEED;
          clfsr_d = SEED;
          addr_d  = '0;
          chk_d   = '0;
          first_d = '0;
          beat_d  = '0;
          err_d   = '0;
          out_d   = '0;
        end
      end
      S_WAIT_INIT: begin
        if (local_init_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (wr_acc) begin
          wlfsr_d = lfsr_step(wlfsr_q);
          if (beat_q == BL_M1) begin
            beat_d = '0;
            if (addr_q == LAST_BASE) begin
              state_d = S_READ;
              addr_d  = '0;
              clfsr_d = SEED;
              out_d   = '0;
            end else begin
              addr_d = addr_q + BL_A;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          addr_d = addr_q + BL_A;
          if (addr_q == LAST_BASE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // In-order read data: each beat is checked against the regenerated pattern.
    if (rd_beat) begin
      clfsr_d = lfsr_step(clfsr_q);
      chk_d   = chk_q + ADDR_W'(1);
      if (local_rdata != clfsr_q[DATA_W-1:0]) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'h0000) first_d = chk_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wlfsr_q <= SEED;
      clfsr_q <= SEED;
      addr_q  <= '0;
      chk_q   <= '0;
      first_q <= '0;
      beat_q  <= '0;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wlfsr_q <= wlfsr_d;
      clfsr_q <= clfsr_d;
      addr_q  <= addr_d;
      chk_q   <= chk_d;
      first_q <= first_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign local_address    = addr_q;
  assign local_write_req  = wr_req;
  assign local_read_req   = rd_req;
  assign local_burstbegin = (wr_req && (beat_q == 3'd0)) || rd_req;
  assign local_size       = 3'(BURST_LEN);
  assign local_be         = '1;
  assign local_wdata      = wr_req ? wlfsr_q[DATA_W-1:0] : '0;
  assign busy             = (state_q == S_WAIT_INIT) || (state_q == S_WRITE) ||
                            (state_q == S_READ) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == 16'h0000);
  assign error_count      = err_q;
  assign first_err_addr   = first_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_local_traffic_master.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr2_local_traffic_master
// Brief  : Randomised bench with memory model and pattern scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_ddr2_local_traffic_master;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int BL     = 2;
  localparam int NW     = 8;
  localparam int MAXO   = 4;
  localparam int NR     = NW / BL;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              local_init_done = 1'b1;
  logic              local_ready = 1'b1;
  logic [DATA_W-1:0] local_rdata = '0;
  logic              local_rdata_valid = 1'b0;
  logic [ADDR_W-1:0] local_address;
  logic              local_write_req, local_read_req, local_burstbegin;
  logic [2:0]        local_size;
  logic [BE_W-1:0]   local_be;
  logic [DATA_W-1:0] local_wdata;
  logic              busy, done, pass;
  logic [15:0]       error_count;
  logic [ADDR_W-1:0] first_err_addr;

  ddr2_local_traffic_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_LEN(BL),
    .NUM_WORDS(NW), .MAX_OUTSTANDING(MAXO), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .local_init_done(local_init_done),
    .local_ready(local_ready), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid), .local_address(local_address),
    .local_write_req(local_write_req), .local_read_req(local_read_req),
    .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_be(local_be), .local_wdata(local_wdata), .busy(busy), .done(done),
    .pass(pass), .error_count(error_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_pat [NW];
  logic [31:0] mem [NW];
  logic [NW-1:0] corrupt = '0;
  int  pend [$];
  bit  rand_ready = 1'b0;
  bit  hold = 1'b0;
  bit  mon_en = 1'b0;
  int  ret_idx, wk, rk, rb, out_b, err_m, first_m, wbb;
  bit  prev_wr_stall, prev_rd_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    wk = 0; rk = 0; rb = 0; out_b = 0; err_m = 0; first_m = 0; wbb = 0;
    ret_idx = 0; prev_wr_stall = 0; prev_rd_stall = 0;
    pend.delete();
  endtask

  // Memory side: random ready, in-order read return, optional beat corruption.
  always @(posedge clk) begin
    #1;
    local_rdata_valid = 1'b0;
    local_rdata = '0;
    local_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset && !hold && pend.size() > 0 && (!rand_ready || $urandom_range(0, 1) == 1)) begin
      int a;
      a = pend.pop_front();
      local_rdata = mem[a] ^ ((ret_idx < NW && corrupt[ret_idx]) ? 32'h1 : 32'h0);
      local_rdata_valid = 1'b1;
      ret_idx++;
    end
  end

  // Per-cycle comparison of the request stream and result against the model.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (prev_wr_stall) check("wr_held_in_stall", local_write_req, 1);
      if (prev_rd_stall) check("rd_held_in_stall", local_read_req, 1);
      if (local_write_req) begin
        check("wr_rd_exclusive", local_read_req, 0);
        check("wr_in_range", wk < NW, 1);
        check("wr_addr", local_address, (wk / BL) * BL);
        check("wdata", local_wdata, exp_pat[wk % NW]);
        check("wr_burstbegin", local_burstbegin, (wk % BL) == 0);
      end
      if (local_read_req) begin
        check("rd_in_range", rk < NR, 1);
        check("rd_addr", local_address, rk * BL);
        check("rd_burstbegin", local_burstbegin, 1);
        check("rd_window", (out_b + BL) <= MAXO, 1);
      end
      if (busy && wk == NW && rk < NR && (out_b + BL) <= MAXO)
        check("rd_issue", local_read_req, 1);
      if (local_rdata_valid) begin
        if (rb < NW && local_rdata !== exp_pat[rb]) begin
          if (err_m == 0) first_m = rb;
          err_m++;
        end
        rb++;
        out_b--;
      end
      if (local_write_req && local_ready) begin
        if (32'(local_address) + (wk % BL) < NW)
          mem[32'(local_address) + (wk % BL)] = local_wdata;
        if (local_burstbegin) wbb++;
        wk++;
      end
      if (local_read_req && local_ready) begin
        for (int b = 0; b < BL; b++) pend.push_back(32'(local_address) + b);
        rk++;
        out_b += BL;
      end
      prev_wr_stall = local_write_req && !local_ready;
      prev_rd_stall = local_read_req && !local_ready;
    end
  end

  task automatic start_test();
    @(posedge clk); #1;
    model_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check({name, "_done"}, done, 1);
  endtask

  task automatic final_checks(input string name, input int exp_err, input int exp_first);
    check({name, "_busy"}, busy, 0);
    check({name, "_err_lit"}, error_count, exp_err);
    check({name, "_err_model"}, error_count, err_m);
    check({name, "_first_lit"}, first_err_addr, exp_first);
    check({name, "_first_model"}, first_err_addr, first_m);
    check({name, "_pass"}, pass, exp_err == 0);
    check({name, "_wr_beats"}, wk, NW);
    check({name, "_rd_reqs"}, rk, NR);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < NW; i++) begin
      exp_pat[i] = s;
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
    for (int i = 0; i < NW; i++) mem[i] = '0;
    model_reset();
    check("pat0", exp_pat[0], 32'h0000_0001);
    check("pat1", exp_pat[1], 32'h8020_0003);
    check("pat2", exp_pat[2], 32'hC030_0002);
    check("pat3", exp_pat[3], 32'h6018_0001);

    repeat (3) @(negedge clk);
    check("rst_wr_req", local_write_req, 0);
    check("rst_rd_req", local_read_req, 0);
    check("rst_bb", local_burstbegin, 0);
    check("rst_size", local_size, 2);
    check("rst_be", local_be, 4'hF);
    check("rst_wdata", local_wdata, 0);
    check("rst_addr", local_address, 0);
    check("rst_flags", {busy, done, pass}, 0);
    check("rst_err", error_count, 0);
    check("rst_first", first_err_addr, 0);
    @(posedge clk); #1 reset = 1'b0;
    mon_en = 1'b1;

    // Ideal memory, ready always high.
    start_test();
    wait_done("ideal");
    final_checks("ideal", 0, 0);
    check("ideal_write_bursts", wbb, 4);

    // Single and double corrupted read beats.
    corrupt = '0; corrupt[5] = 1'b1;
    start_test();
    wait_done("flip5");
    final_checks("flip5", 1, 5);
    corrupt[6] = 1'b1;
    start_test();
    wait_done("flip56");
    final_checks("flip56", 2, 5);
    corrupt = '0;

    // Random ready stalls and random read latency.
    rand_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      start_test();
      wait_done("stall");
      final_checks("stall", 0, 0);
    end
    rand_ready = 1'b0;

    // Withheld read data limits the in-flight window.
    hold = 1'b1;
    start_test();
    for (int i = 0; i < 200 && rk < 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("hold_rd_count", rk, 2);
    check("hold_rd_req", local_read_req, 0);
    check("hold_busy", busy, 1);
    @(posedge clk); #1 hold = 1'b0;
    wait_done("hold");
    final_checks("hold", 0, 0);

    // Calibration not complete: no traffic until init_done.
    local_init_done = 1'b0;
    start_test();
    begin
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (local_write_req || local_read_req || !busy) quiet = 1'b0;
      end
      check("init_wait_quiet", quiet, 1);
    end
    @(posedge clk); #1 local_init_done = 1'b1;
    @(negedge clk);
    check("init_not_yet", local_write_req, 0);
    @(negedge clk);
    check("init_write_begins", local_write_req, 1);
    wait_done("init");
    final_checks("init", 0, 0);

    // Asynchronous reset in the middle of the write phase.
    start_test();
    for (int i = 0; i < 100 && wk < 3; i++) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("arst_wr_req", local_write_req, 0);
    check("arst_rd_req", local_read_req, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", local_address, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    start_test();
    wait_done("after_rst");
    final_checks("after_rst", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
